// File: rtl/pipeline_pkg.sv
// Shared types, default sizing and refill-length helper for the pipeline flush controller.
package pipeline_pkg;

  localparam int DEF_NUM_STAGES    = 5;
  localparam int DEF_RESOLVE_STAGE = 2;
  localparam int DEF_XLEN          = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } flush_state_e;

  // Bubble cycles left behind by an event: everything younger than the event's stage.
  function automatic int unsigned refill_len(
    input logic        is_trap,
    input int unsigned num_stages    = DEF_NUM_STAGES,
    input int unsigned resolve_stage = DEF_RESOLVE_STAGE
  );
    return is_trap ? (num_stages - 1) : resolve_stage;
  endfunction

endpackage

// File: rtl/flush_refill_counter.sv
// Loadable down-counter that tracks remaining refill bubbles; a load restarts the count.
module flush_refill_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] cnt_o,
  output logic         busy_o,
  output logic         last_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign busy_o = (cnt_q != '0);
  assign last_o = (cnt_q == W'(1));

endmodule

// File: rtl/pipeline_flush_ctrl.sv
// Per-stage flush, PC redirect, refill tracking and stall gating for an in-order pipeline.
// Optional flush statistics counter enabled by defining PIPELINE_FLUSH_STATS_EN.
module pipeline_flush_ctrl
  import pipeline_pkg::*;
#(
  parameter int NUM_STAGES    = DEF_NUM_STAGES,
  parameter int RESOLVE_STAGE = DEF_RESOLVE_STAGE,
  parameter int XLEN          = DEF_XLEN
`ifdef PIPELINE_FLUSH_STATS_EN
  ,
  parameter int CNT_W         = 16
`endif
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            branch_taken_i,
  input  logic [XLEN-1:0]                 branch_target_i,
  input  logic                            trap_i,
  input  logic [XLEN-1:0]                 trap_vector_i,
  input  logic                            stall_req_i,
  output logic [NUM_STAGES-1:0]           flush_o,
  output logic                            stall_o,
  output logic                            redirect_valid_o,
  output logic [XLEN-1:0]                 redirect_pc_o,
  output logic                            refill_busy_o,
  output logic [$clog2(NUM_STAGES+1)-1:0] refill_cnt_o
`ifdef PIPELINE_FLUSH_STATS_EN
  ,
  output logic [CNT_W-1:0]                flush_count_o
`endif
);

  localparam int CW = $clog2(NUM_STAGES + 1);
  localparam logic [NUM_STAGES-1:0] BR_MASK   = NUM_STAGES'((1 << RESOLVE_STAGE) - 1);
  localparam logic [NUM_STAGES-1:0] TRAP_MASK = NUM_STAGES'((1 << (NUM_STAGES - 1)) - 1);

  flush_state_e  state_q, state_d;
  logic          event_any;
  logic [CW-1:0] load_val;
  logic [CW-1:0] cnt;
  logic          cnt_busy;
  logic          cnt_last;

  // Trap wins over a same-cycle branch; everything is held at zero during reset.
  always_comb begin
    flush_o          = '0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = '0;
    if (rst_n) begin
      if (trap_i) begin
        flush_o          = TRAP_MASK;
        redirect_valid_o = 1'b1;
        redirect_pc_o    = trap_vector_i;
      end else if (branch_taken_i) begin
        flush_o          = BR_MASK;
        redirect_valid_o = 1'b1;
        redirect_pc_o    = branch_target_i;
      end
    end
    stall_o = rst_n & stall_req_i & ~redirect_valid_o;
  end

  assign event_any = branch_taken_i | trap_i;
  assign load_val  = CW'(refill_len(trap_i, NUM_STAGES, RESOLVE_STAGE));

  flush_refill_counter #(
    .W (CW)
  ) u_refill_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (event_any),
    .load_val_i (load_val),
    .cnt_o      (cnt),
    .busy_o     (cnt_busy),
    .last_o     (cnt_last)
  );

  always_comb begin
    state_d = state_q;
    if (event_any) begin
      state_d = REFILL;
    end else if (state_q == REFILL && (cnt_last || !cnt_busy)) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign refill_busy_o = (state_q == REFILL);
  assign refill_cnt_o  = cnt;

`ifdef PIPELINE_FLUSH_STATS_EN
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  // Saturating count of redirect cycles.
  always_comb begin
    flush_count_d = flush_count_q;
    if (redirect_valid_o && (flush_count_q != '1)) begin
      flush_count_d = flush_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flush_count_q <= '0;
    end else begin
      flush_count_q <= flush_count_d;
    end
  end

  assign flush_count_o = flush_count_q;
`endif

endmodule

// File: tb/tb_pipeline_flush_ctrl.sv
// Self-checking bench for pipeline_flush_ctrl: vector table, directed refill sequences, random vs model.
// Stats checks are compiled in when PIPELINE_FLUSH_STATS_EN is defined.
module tb_pipeline_flush_ctrl;

  localparam int NS  = 5;
  localparam int RS  = 2;
  localparam int XL  = 32;
  localparam int CW  = $clog2(NS + 1);
`ifdef PIPELINE_FLUSH_STATS_EN
  localparam int SW  = 2;
  localparam int SAT = (1 << SW) - 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          branch_taken_i;
  logic [XL-1:0] branch_target_i;
  logic          trap_i;
  logic [XL-1:0] trap_vector_i;
  logic          stall_req_i;
  logic [NS-1:0] flush_o;
  logic          stall_o;
  logic          redirect_valid_o;
  logic [XL-1:0] redirect_pc_o;
  logic          refill_busy_o;
  logic [CW-1:0] refill_cnt_o;
`ifdef PIPELINE_FLUSH_STATS_EN
  logic [SW-1:0] flush_count_o;
`endif

  always #5 clk = ~clk;

  pipeline_flush_ctrl #(
    .NUM_STAGES    (NS),
    .RESOLVE_STAGE (RS),
    .XLEN          (XL)
`ifdef PIPELINE_FLUSH_STATS_EN
    ,
    .CNT_W         (SW)
`endif
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .branch_taken_i   (branch_taken_i),
    .branch_target_i  (branch_target_i),
    .trap_i           (trap_i),
    .trap_vector_i    (trap_vector_i),
    .stall_req_i      (stall_req_i),
    .flush_o          (flush_o),
    .stall_o          (stall_o),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o),
    .refill_busy_o    (refill_busy_o),
    .refill_cnt_o     (refill_cnt_o)
`ifdef PIPELINE_FLUSH_STATS_EN
    ,
    .flush_count_o    (flush_count_o)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic br, input logic tr, input logic st,
                       input logic [XL-1:0] tgt, input logic [XL-1:0] vec);
    rst_n           = r;
    branch_taken_i  = br;
    trap_i          = tr;
    stall_req_i     = st;
    branch_target_i = tgt;
    trap_vector_i   = vec;
  endtask

  // Inputs change 1 unit after the rising edge, outputs are sampled 2 units later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          r, br, tr, st;
    logic [XL-1:0] tgt, vec;
    logic [NS-1:0] e_flush;
    logic          e_stall, e_rv;
    logic [XL-1:0] e_pc;
    logic          e_busy;
    logic [CW-1:0] e_cnt;
  } vec_t;

  vec_t tbl [0:14];

  // Reference model: remaining bubbles as a plain integer.
  int m_cnt;
  int m_stat;

  task automatic model_check(input string tag);
    logic [NS-1:0] ef;
    logic          erv;
    logic [XL-1:0] epc;
    ef  = '0;
    erv = 1'b0;
    epc = '0;
    if (rst_n && (trap_i || branch_taken_i)) begin
      erv = 1'b1;
      epc = trap_i ? trap_vector_i : branch_target_i;
      for (int i = 0; i < NS; i++) ef[i] = trap_i ? (i < NS - 1) : (i < RS);
    end
    chk({tag, "_flush"}, 64'(flush_o), 64'(ef));
    chk({tag, "_rv"}, 64'(redirect_valid_o), 64'(erv));
    chk({tag, "_pc"}, 64'(redirect_pc_o), 64'(epc));
    chk({tag, "_stall"}, 64'(stall_o), 64'(rst_n & stall_req_i & ~erv));
    chk({tag, "_cnt"}, 64'(refill_cnt_o), 64'(m_cnt));
    chk({tag, "_busy"}, 64'(refill_busy_o), 64'(m_cnt != 0));
`ifdef PIPELINE_FLUSH_STATS_EN
    chk({tag, "_stat"}, 64'(flush_count_o), 64'(m_stat));
    if (!rst_n) m_stat = 0;
    else if (erv && m_stat < SAT) m_stat++;
`endif
    if (!rst_n) m_cnt = 0;
    else if (trap_i) m_cnt = NS - 1;
    else if (branch_taken_i) m_cnt = RS;
    else if (m_cnt > 0) m_cnt--;
  endtask

  initial begin
    tbl[0]  = '{1, 0, 0, 0, 32'h0,   32'h0,         5'b00000, 0, 0, 32'h0,         0, 0};
    tbl[1]  = '{1, 1, 0, 0, 32'h100, 32'h0,         5'b00011, 0, 1, 32'h100,       0, 0};
    tbl[2]  = '{1, 0, 0, 0, 32'h0,   32'h0,         5'b00000, 0, 0, 32'h0,         1, 2};
    tbl[3]  = '{1, 0, 0, 0, 32'h0,   32'h0,         5'b00000, 0, 0, 32'h0,         1, 1};
    tbl[4]  = '{1, 0, 0, 0, 32'h0,   32'h0,         5'b00000, 0, 0, 32'h0,         0, 0};
    tbl[5]  = '{1, 1, 1, 0, 32'h200, 32'h8000_0000, 5'b01111, 0, 1, 32'h8000_0000, 0, 0};
    tbl[6]  = '{1, 0, 0, 0, 32'h0,   32'h0,         5'b00000, 0, 0, 32'h0,         1, 4};
    tbl[7]  = '{1, 0, 0, 1, 32'h0,   32'h0,         5'b00000, 1, 0, 32'h0,         1, 3};
    tbl[8]  = '{1, 0, 0, 1, 32'h0,   32'h0,         5'b00000, 1, 0, 32'h0,         1, 2};
    tbl[9]  = '{1, 1, 0, 1, 32'h44,  32'h0,         5'b00011, 0, 1, 32'h44,        1, 1};
    tbl[10] = '{1, 0, 0, 1, 32'h0,   32'h0,         5'b00000, 1, 0, 32'h0,         1, 2};
    tbl[11] = '{1, 1, 0, 0, 32'h10,  32'h0,         5'b00011, 0, 1, 32'h10,        1, 1};
    tbl[12] = '{1, 0, 1, 0, 32'h0,   32'h1000,      5'b01111, 0, 1, 32'h1000,      1, 2};
    tbl[13] = '{0, 1, 0, 1, 32'habc, 32'h0,         5'b00000, 0, 0, 32'h0,         1, 4};
    tbl[14] = '{1, 0, 0, 0, 32'h0,   32'h0,         5'b00000, 0, 0, 32'h0,         0, 0};

    drive(0, 0, 0, 0, '0, '0);
    repeat (2) @(posedge clk);
    #1;

    for (int k = 0; k < 15; k++) begin
      drive(tbl[k].r, tbl[k].br, tbl[k].tr, tbl[k].st, tbl[k].tgt, tbl[k].vec);
      #2;
      chk($sformatf("tbl%0d_flush", k), 64'(flush_o), 64'(tbl[k].e_flush));
      chk($sformatf("tbl%0d_stall", k), 64'(stall_o), 64'(tbl[k].e_stall));
      chk($sformatf("tbl%0d_rv", k), 64'(redirect_valid_o), 64'(tbl[k].e_rv));
      chk($sformatf("tbl%0d_pc", k), 64'(redirect_pc_o), 64'(tbl[k].e_pc));
      chk($sformatf("tbl%0d_busy", k), 64'(refill_busy_o), 64'(tbl[k].e_busy));
      chk($sformatf("tbl%0d_cnt", k), 64'(refill_cnt_o), 64'(tbl[k].e_cnt));
      tick();
    end

    // Branch during a trap refill restarts at the branch length instead of adding.
    drive(1, 0, 1, 0, '0, 32'h2000);
    tick();
    drive(1, 1, 0, 0, 32'h300, '0);
    #2;
    chk("seq_cnt_before_br", 64'(refill_cnt_o), 64'd4);
    tick();
    drive(1, 0, 0, 0, '0, '0);
    #2;
    chk("seq_cnt_restart", 64'(refill_cnt_o), 64'd2);
    tick();
    #2;
    chk("seq_cnt_last", 64'(refill_cnt_o), 64'd1);
    chk("seq_busy_last", 64'(refill_busy_o), 64'd1);
    tick();
    #2;
    chk("seq_idle_cnt", 64'(refill_cnt_o), 64'd0);
    chk("seq_idle_busy", 64'(refill_busy_o), 64'd0);
    tick();

`ifdef PIPELINE_FLUSH_STATS_EN
    begin
      int exp_stat [0:4];
      exp_stat = '{1, 2, 3, 3, 3};
      drive(0, 0, 0, 0, '0, '0);
      tick();
      drive(1, 0, 0, 0, '0, '0);
      #2;
      chk("stat_reset", 64'(flush_count_o), 64'd0);
      for (int k = 0; k < 5; k++) begin
        drive(1, 1, 0, 0, 32'h40 * k, '0);
        tick();
        #2;
        chk($sformatf("stat_br%0d", k), 64'(flush_count_o), 64'(exp_stat[k]));
      end
    end
`endif

    // Randomized run against the model, starting from a known reset.
    drive(0, 0, 0, 0, '0, '0);
    tick();
    m_cnt  = 0;
    m_stat = 0;
    for (int n = 0; n < 2000; n++) begin
      drive($urandom_range(0, 39) != 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)),
            $urandom, $urandom);
      #2;
      model_check("rnd");
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_flush_ctrl.md
Name: pipeline_flush_ctrl

Overview:
- Parametrised successor to the single-wire flush: per-stage flush vector, PC redirect, refill tracking and stall arbitration for an N-stage in-order pipeline.
- Sits beside the hazard unit. Takes taken-branch and trap events from the resolve/commit stages. Drives per-stage flush, redirect and stall-gating to the pipeline registers and fetch.

Parameters:
- NUM_STAGES, 5, number of pipeline stages; index 0 = fetch, NUM_STAGES-1 = writeback.
- RESOLVE_STAGE, 2, stage where branches resolve; must satisfy 1 <= RESOLVE_STAGE <= NUM_STAGES-2.
- XLEN, 32, PC width.
- CNT_W, 16, width of the flush statistics counter (used only when the optional feature is enabled).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- branch_taken_i  in  1  taken branch/jump resolved in RESOLVE_STAGE this cycle.
- branch_target_i  in  XLEN  target PC for branch_taken_i.
- trap_i  in  1  exception/trap raised at stage NUM_STAGES-2.
- trap_vector_i  in  XLEN  handler PC for trap_i.
- stall_req_i  in  1  load-use stall request from the hazard unit.
- flush_o  out  NUM_STAGES  per-stage flush; bit i kills the instruction entering stage i+1.
- stall_o  out  1  gated stall to the fetch and decode registers.
- redirect_valid_o  out  1  fetch must load redirect_pc_o this cycle.
- redirect_pc_o  out  XLEN  redirect PC.
- refill_busy_o  out  1  pipeline still contains flush bubbles.
- refill_cnt_o  out  $clog2(NUM_STAGES+1)  remaining bubble cycles.
- flush_count_o  out  CNT_W  present only with FLUSH_STATS_EN.

Behaviour:
- Flush, redirect and stall outputs are combinational from the current-cycle inputs (0-cycle latency, as in the previous generation). State and counters update on the rising edge of clk.
- branch_taken_i only:
  - flush_o[RESOLVE_STAGE-1:0] = all ones; other bits 0.
  - redirect_valid_o = 1; redirect_pc_o = branch_target_i.
- trap_i (with or without branch_taken_i):
  - flush_o[NUM_STAGES-2:0] = all ones; bit NUM_STAGES-1 = 0.
  - redirect_pc_o = trap_vector_i.
  - Trap has priority over branch; branch_target_i is ignored.
- Neither event: flush_o = 0, redirect_valid_o = 0, redirect_pc_o = 0.
- stall_o = stall_req_i & ~redirect_valid_o. A flush overrides a stall because the stalled instruction is being killed.
- FSM states:
  - IDLE -> REFILL on any event. refill_cnt loads RESOLVE_STAGE for a branch, NUM_STAGES-1 for a trap.
  - REFILL: cnt decrements each cycle; returns to IDLE on the cycle cnt would reach 0.
  - A new event in REFILL reloads cnt per the rule above (it restarts the count; it does not add). A trap therefore always loads the larger value.
- refill_busy_o = (state == REFILL). refill_cnt_o = cnt, which is 0 in IDLE.
- Reset (rst_n low at a clock edge): state = IDLE, cnt = 0, flush_count = 0.
  - Reset takes effect mid-REFILL as well.
  - While rst_n is low, all combinational outputs are forced to 0, including flush_o and redirect_valid_o.
- Events have no handshake. An event is assumed valid for exactly the cycle it is asserted.

Optional Feature:
- Macro: PIPELINE_FLUSH_STATS_EN.
- When defined:
  - flush_count_o port exists.
  - Counter increments by 1 on each cycle with redirect_valid_o = 1.
  - Counter saturates at all ones and resets to 0.
- When undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package pipeline_pkg holds:
  - typedef flush_state_e {IDLE, REFILL}.
  - Localparam defaults for NUM_STAGES, RESOLVE_STAGE and XLEN.
  - Function refill_len(is_trap) returning the reload value.
- One sub-module, flush_refill_counter: loadable down-counter with a busy flag, parametrised by width.

Test Plan:
- Reset then idle, NUM_STAGES=5, RESOLVE_STAGE=2 -> flush_o=5'b00000, redirect_valid_o=0, refill_busy_o=0, cnt=0.
- branch_taken_i=1 for 1 cycle, target 0x0000_0100 -> same cycle flush_o=5'b00011, redirect_pc_o=0x100; busy high for 2 cycles with cnt 2, 1; then IDLE.
- trap_i and branch_taken_i together, vector 0x8000_0000 -> flush_o=5'b01111, redirect_pc_o=0x8000_0000, cnt loads 4.
- stall_req_i=1 held and branch in cycle 3 -> stall_o=1 except cycle 3, where stall_o=0 and flush_o=5'b00011.
- Branch, then trap 1 cycle later (cnt=1) -> cnt reloads to 4; rst_n low next cycle -> cnt=0, busy=0, flush_o=0.
- With PIPELINE_FLUSH_STATS_EN and CNT_W=2: 5 branches -> flush_count_o sequence 1, 2, 3, 3, 3 (saturates at 3).
